// File: rtl/inst_fetch_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// default reset vector, the NOP word used for address-error entries, the
// fetch-buffer depth and the buffer entry layout.
// ----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam int unsigned FBUF_DEPTH       = 2;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        iaddr_err;
    } fbuf_entry_t;

    // Sequential PC advance; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/inst_fetch_fetch_buf.sv
// ----------------------------------------------------------------------------
// fetch_buf
// Two-entry FIFO of {inst, pc, iaddr_err}. Entry 0 is always the head, so the
// head outputs come straight from a register and keep the last dequeued value
// when the buffer drains.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   enq          write enq_entry this cycle
//   enq_entry    entry to write
//   deq          drop the head this cycle (ignored when empty)
//   clear        empty the buffer (wins over enq/deq)
//   head         current head entry
//   count        number of valid entries (0..2)
// ----------------------------------------------------------------------------
module fetch_buf
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enq,
    input  fbuf_entry_t enq_entry,
    input  logic        deq,
    input  logic        clear,
    output fbuf_entry_t head,
    output logic [1:0]  count
);

    fbuf_entry_t e0_q, e0_d;
    fbuf_entry_t e1_q, e1_d;
    logic [1:0]  count_q, count_d;
    logic        deq_s;

    // Next-state of the shift-style FIFO slots and occupancy.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        deq_s   = deq & (count_q != 2'd0);
        if (clear) begin
            count_d = 2'd0;
        end else begin
            case ({enq, deq_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_d    = enq_entry;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        e1_d    = enq_entry;
                        count_d = 2'd2;
                    end else begin
                        count_d = count_q;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        e0_d    = e1_q;
                        count_d = 2'd1;
                    end else begin
                        // Single entry leaves: head slot keeps the old word.
                        count_d = 2'd0;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = enq_entry;
                    end else begin
                        e0_d = enq_entry;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign head  = e0_q;
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage: owns the PC, drives the instruction-bus read
// handshake (with wait states), buffers up to two fetched words and hands
// {inst, pc_value} to decode over a valid/ready handshake. Redirects flush the
// buffer; a request already stalled on the bus is allowed to finish (FLUSH)
// and its data is thrown away.
// Optional build macro: FETCH_ALIGN_CHECK_EN -- misaligned PCs produce an
// address-error entry instead of a bus read, and fetch halts until redirect.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ibus_address/ibus_read     read request to the instruction bus
//   ibus_rddata/ibus_stall     read data and wait-state input
//   redirect/redirect_pc       flush and restart fetch at redirect_pc
//   inst/pc_value/inst_valid   head entry to decode
//   id_ready                   decode consumes head when inst_valid & id_ready
//   iaddr_err                  head entry carries an address error
// ----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ibus_address,
    output logic        ibus_read,
    input  logic [31:0] ibus_rddata,
    input  logic        ibus_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] pc_value,
    output logic        inst_valid,
    input  logic        id_ready,
    output logic        iaddr_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;

    fbuf_entry_t  head_s;
    fbuf_entry_t  enq_entry_s;
    logic [1:0]   buf_count_s;
    logic [1:0]   occ_after_s;
    logic         deq_raw_s;
    logic         deq_s;
    logic         enq_s;
    logic         clear_s;
    logic         space_s;
    logic         misalign_s;

    assign inst_valid  = (buf_count_s != 2'd0);
    assign deq_raw_s   = inst_valid & id_ready;
    // Space test sees this cycle's dequeue so a full buffer being drained
    // can still issue (gives back-to-back throughput).
    assign occ_after_s = buf_count_s - {1'b0, deq_raw_s};
    assign space_s     = (occ_after_s < 2'd2);
    // A redirect cycle never consumes: the buffer is being thrown away.
    assign deq_s       = deq_raw_s & ~redirect;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_s = (pc_q[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // FSM next state, PC/held-address update and bus/buffer controls.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        ibus_read    = 1'b0;
        ibus_address = pc_q;
        enq_s        = 1'b0;
        clear_s      = 1'b0;
        enq_entry_s  = '{inst: ibus_rddata, pc: pc_q, iaddr_err: 1'b0};

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (space_s && misalign_s) begin
                    // Address error: no bus access, PC stays put.
                    enq_s       = 1'b1;
                    enq_entry_s = '{inst: INST_NOP, pc: pc_q, iaddr_err: 1'b1};
                end else if (space_s) begin
                    ibus_read = 1'b1;
                    if (ibus_stall) begin
                        addr_d  = pc_q;
                        state_d = redirect ? ST_FLUSH : ST_WAIT;
                    end else begin
                        enq_s = 1'b1;
                        pc_d  = pc_next(pc_q);
                    end
                end else begin
                    ibus_read = 1'b0;
                end
            end
            ST_WAIT: begin
                ibus_read    = 1'b1;
                ibus_address = addr_q;
                if (!ibus_stall) begin
                    enq_s   = 1'b1;
                    pc_d    = pc_next(addr_q);
                    state_d = ST_FETCH;
                end else if (redirect) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                // Finish the stale access; its data is never enqueued.
                ibus_read    = 1'b1;
                ibus_address = addr_q;
                if (!ibus_stall) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect overrides any enqueue and PC update from above.
        if (redirect) begin
            pc_d    = redirect_pc;
            clear_s = 1'b1;
            enq_s   = 1'b0;
        end else begin
            clear_s = 1'b0;
        end
    end

    // FSM, PC and held-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            addr_q  <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    fetch_buf u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq       (enq_s),
        .enq_entry (enq_entry_s),
        .deq       (deq_s),
        .clear     (clear_s),
        .head      (head_s),
        .count     (buf_count_s)
    );

    assign inst      = head_s.inst;
    assign pc_value  = head_s.pc;
    // Entries only carry a set error bit when the alignment check is built in.
    assign iaddr_err = inst_valid & head_s.iaddr_err;

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. Memory answers with zero latency and returns
// address ^ 32'hFFFF0000; stalls, id_ready and redirects are driven per cycle
// and every expected value below is worked out by hand from the cycle
// numbering (cycle 0 = the IDLE cycle right after reset release).
// ----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] pc_value;
    logic        inst_valid;
    logic        id_ready;
    logic        iaddr_err;

    int n_checks;
    int n_errors;

    inst_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus_address (ibus_address),
        .ibus_read    (ibus_read),
        .ibus_rddata  (ibus_rddata),
        .ibus_stall   (ibus_stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inst         (inst),
        .pc_value     (pc_value),
        .inst_valid   (inst_valid),
        .id_ready     (id_ready),
        .iaddr_err    (iaddr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ibus_rddata = ibus_address ^ 32'hFFFF_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then settle for sampling.
    task automatic cyc(input logic rd, input logic st, input logic rdr, input logic [31:0] rpc);
        @(negedge clk);
        id_ready    = rd;
        ibus_stall  = st;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
    endtask

    // Pulse reset, release it on a falling edge; returns inside cycle 0.
    task automatic do_reset(input logic rd);
        @(negedge clk);
        rst_n      = 1'b0;
        redirect   = 1'b0;
        ibus_stall = 1'b0;
        id_ready   = rd;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, pc_value, pc);
        chk({tag, "_inst"}, inst, pc ^ 32'hFFFF_0000);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        id_ready    = 1'b1;
        ibus_stall  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_inst", inst, 32'h0000_0000);
        chk("rst_pc_value", pc_value, 32'h0000_0000);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_iaddr_err", {31'd0, iaddr_err}, 32'd0);
        chk("rst_ibus_read", {31'd0, ibus_read}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // ---- streaming with zero-wait memory ----
        chk("idle_read", {31'd0, ibus_read}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stream_read", {31'd0, ibus_read}, 32'd1);
            chk("stream_addr", ibus_address, 32'hBFC0_0000 + 32'(4 * k));
            if (k == 0) begin
                chk("stream_first_empty", {31'd0, inst_valid}, 32'd0);
            end else begin
                chk_head("stream", 32'hBFC0_0000 + 32'(4 * (k - 1)));
                chk("stream_err", {31'd0, iaddr_err}, 32'd0);
            end
        end

        // ---- back-pressure: buffer fills to 2 then drains in order ----
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_c1_addr", ibus_address, 32'hBFC0_0000);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_c2_addr", ibus_address, 32'hBFC0_0004);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_c3_read", {31'd0, ibus_read}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("bp_c4_read", {31'd0, ibus_read}, 32'd0);
        chk_head("bp_c4_head", 32'hBFC0_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("bp_c5_head", 32'hBFC0_0000);
        chk("bp_c5_read", {31'd0, ibus_read}, 32'd1);
        chk("bp_c5_addr", ibus_address, 32'hBFC0_0008);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("bp_c6_head", 32'hBFC0_0004);
        chk("bp_c6_addr", ibus_address, 32'hBFC0_000C);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("bp_c7_head", 32'hBFC0_0008);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("bp_c8_head", 32'hBFC0_000C);

        // ---- 3-cycle stall on BFC00004 ----
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("st_c2_addr", ibus_address, 32'hBFC0_0004);
        chk_head("st_c2_head", 32'hBFC0_0000);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, (k < 2) ? 1'b1 : 1'b0, 1'b0, 32'h0);
            chk("st_hold_read", {31'd0, ibus_read}, 32'd1);
            chk("st_hold_addr", ibus_address, 32'hBFC0_0004);
            chk("st_hold_empty", {31'd0, inst_valid}, 32'd0);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("st_c6_head", 32'hBFC0_0004);
        chk("st_c6_addr", ibus_address, 32'hBFC0_0008);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("st_c7_head", 32'hBFC0_0008);

        // ---- redirect while BFC00008 is stalled ----
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("fl_c3_addr", ibus_address, 32'hBFC0_0008);
        cyc(1'b1, 1'b1, 1'b1, 32'h8000_1000);
        chk("fl_c4_addr", ibus_address, 32'hBFC0_0008);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("fl_c5_read", {31'd0, ibus_read}, 32'd1);
        chk("fl_c5_addr", ibus_address, 32'hBFC0_0008);
        chk("fl_c5_empty", {31'd0, inst_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("fl_c6_addr", ibus_address, 32'h8000_1000);
        chk("fl_c6_empty", {31'd0, inst_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("fl_c7_head", 32'h8000_1000);
        chk("fl_c7_addr", ibus_address, 32'h8000_1004);

        // ---- redirect with full buffer during a dequeue, then PC wrap ----
        do_reset(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 32'h8000_2000);
        chk_head("rf_c3_head", 32'hBFC0_0000);
        chk("rf_c3_addr", ibus_address, 32'hBFC0_0008);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rf_c4_empty", {31'd0, inst_valid}, 32'd0);
        chk("rf_c4_addr", ibus_address, 32'h8000_2000);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("rf_c5_head", 32'h8000_2000);
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wr_c7_empty", {31'd0, inst_valid}, 32'd0);
        chk("wr_c7_addr", ibus_address, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("wr_c8_head", 32'hFFFF_FFFC);
        chk("wr_c8_addr", ibus_address, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("wr_c9_head", 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
        // ---- misaligned redirect target produces an error entry ----
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h8000_0002);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("al_c2_read", {31'd0, ibus_read}, 32'd0);
        chk("al_c2_empty", {31'd0, inst_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'h8000_0000);
        chk("al_c3_read", {31'd0, ibus_read}, 32'd0);
        chk("al_c3_valid", {31'd0, inst_valid}, 32'd1);
        chk("al_c3_pc", pc_value, 32'h8000_0002);
        chk("al_c3_err", {31'd0, iaddr_err}, 32'd1);
        chk("al_c3_inst", inst, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("al_c4_read", {31'd0, ibus_read}, 32'd1);
        chk("al_c4_addr", ibus_address, 32'h8000_0000);
        chk("al_c4_err", {31'd0, iaddr_err}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_head("al_c5_head", 32'h8000_0000);
        chk("al_c5_err", {31'd0, iaddr_err}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage; the producer side of the decode interface. Supplies `inst`/`pc_value` pairs to the ID stage through a valid/ready handshake.
- Owns the PC and drives the instruction-bus read handshake, including wait states.
- Buffers up to 2 fetched words.
- Accepts PC redirects from branch/exception logic and discards stale in-flight data.

Parameters:
- RESET_VECTOR, 32'hBFC00000, first PC fetched after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- ibus_address  out  32  instruction-bus byte address.
- ibus_read  out  1  read request.
- ibus_rddata  in  32  read data; valid in a cycle with ibus_read=1 and ibus_stall=0.
- ibus_stall  in  1  bus wait; the request completes in the first cycle with ibus_stall=0.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC, sampled when redirect=1.
- inst  out  32  head-entry instruction word.
- pc_value  out  32  head-entry PC.
- inst_valid  out  1  head entry valid.
- id_ready  in  1  ID consumes the head when inst_valid & id_ready.
- iaddr_err  out  1  head entry carries an address error (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_VECTOR; buffer empty.
  - inst=0, pc_value=0, inst_valid=0, iaddr_err=0, ibus_read=0.
  - FSM=IDLE.
  - Reset mid-transaction abandons the bus access.
- FSM states:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: request permitted.
  - WAIT: request outstanding, stalled.
  - FLUSH: outstanding request must complete, but its data is discarded.
- Issue rule in FETCH:
  - ibus_read=1, ibus_address=pc when (count - deq) < 2, where deq = inst_valid & id_ready and count is the number of buffer entries (0..2).
  - This is combinational on id_ready.
- Completion:
  - Completion in the same cycle (stall=0): enqueue {ibus_rddata, pc}; pc += 4 (mod 2^32); stay in FETCH.
  - Stall=1: go to WAIT. In WAIT, ibus_read=1 and ibus_address are held constant regardless of id_ready. When stall=0: enqueue, pc += 4, back to FETCH.
  - Overflow is impossible because count does not increase while WAIT is pending.
- Buffer: 2-entry FIFO, head drives inst/pc_value/iaddr_err combinationally, inst_valid = (count != 0). Enqueue and dequeue in the same cycle are allowed at any count; count is unchanged.
- Redirect (highest priority; id_ready ignored that cycle):
  - Buffer cleared next cycle, so inst_valid=0 on the following cycle; pc <= redirect_pc.
  - FETCH with a request completing this cycle, or no request: data dropped, next state FETCH.
  - WAIT, or FETCH with stall=1: next state FLUSH. The old address and ibus_read stay held until stall=0; data dropped, then FETCH at the new pc.
  - FLUSH + redirect: pc updated again, remain in FLUSH.
- Latency: with zero-wait memory and id_ready=1, redirect asserted in cycle t gives ibus_read at new pc in t+1 and inst_valid in t+2. Sustained throughput is 1 instruction/cycle.
- Empty buffer: inst and pc_value hold the last dequeued values (don't-care for ID); iaddr_err=0.

Optional Feature:
- FETCH_ALIGN_CHECK_EN defined:
  - In FETCH with pc[1:0]!=0 and space available, no bus access is made (ibus_read=0).
  - An entry {inst=32'h0, pc, iaddr_err=1} is enqueued that same cycle.
  - pc is not advanced; fetch halts in FETCH until a redirect.
- Undefined: no check is made. iaddr_err is tied to 0 and ibus_address=pc as-is.

Decomposition:
- Shared package/defs file holds:
  - FSM state encodings (IDLE/FETCH/WAIT/FLUSH).
  - RESET_VECTOR default.
  - INST_NOP=32'h0.
  - Fetch-buffer depth constant 2.
- One sub-module: fetch_buf, a 2-entry FIFO of {inst, pc, iaddr_err} with enq/deq/clear and count output.

Test Plan:
- Reset release, zero-wait memory returning data=addr^32'hFFFF0000, id_ready=1 → first ibus_address=BFC00000 two cycles after release. Consecutive inst_valid cycles with pc_value BFC00000, BFC00004, BFC00008…, inst matching.
- id_ready=0 for 5 cycles → exactly 2 entries buffered, ibus_read=0 afterwards. On id_ready=1, BFC00000/04 drain in order with no gap, then fetch resumes at BFC00008.
- ibus_stall=1 for 3 cycles on BFC00004 → ibus_address held at BFC00004 for 4 cycles, single enqueue, no duplicate or skipped PC.
- redirect=1, redirect_pc=80001000 while BFC00008 is stalled 2 cycles → BFC00008 data never appears. Next ibus_address is 80001000 after the stall clears; first valid pc_value is 80001000.
- Redirect in the same cycle as inst_valid&id_ready with a full buffer → inst_valid=0 the next cycle; the next valid pc_value is redirect_pc.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=80000002 → ibus_read stays 0; entry pc_value=80000002, iaddr_err=1, inst=0. A following redirect to 80000000 resumes normal fetch.
